all_gate: RTL and testbench
===========================

Name: all_gate

Overview:
- Basic-logic demonstrator. Applies seven elementary gate functions (AND, OR, NAND, NOR, XOR, XNOR, NOT) to two operands in parallel.
- Presents all seven results on one packed output bus.
- Leaf block in the combinational-primitives library. Used as a reference gate bank and for bench self-checks.
- Results are registered on the single clock, with synchronous active-high reset.

Parameters:
- WIDTH, 1, bit width of each operand; every gate operates bitwise across WIDTH bits.
- REGISTER_OUT, 1:
  - 1 = outputs registered, 1-cycle latency.
  - 0 = outputs purely combinational; clk and rst have no effect.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- y_out  output  7*WIDTH  packed gate results; field g is y_out[g*WIDTH +: WIDTH].

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Field mapping (all bitwise per bit i):
  - field 0 = a & b
  - field 1 = a | b
  - field 2 = ~(a & b)
  - field 3 = ~(a | b)
  - field 4 = a ^ b
  - field 5 = ~(a ^ b)
  - field 6 = ~a
- b_in does not affect field 6.
- With WIDTH=1, y_out is 7 bits, y_out[0]=AND through y_out[6]=NOT a.
- REGISTER_OUT=1:
  - On each rising clk edge with rst=1, y_out <= all zeros.
  - On each rising clk edge with rst=0, y_out <= gate results of the a_in/b_in sampled at that edge.
  - Latency is exactly 1 cycle; a new result every cycle, no stall and no handshake.
- Reset has priority over data. Asserting rst mid-stream clears y_out on the next edge. The first edge after deassertion loads a valid result.
- Before the first clk edge, y_out is undefined. Benches must apply rst for at least 1 cycle.
- REGISTER_OUT=0: y_out follows a_in/b_in combinationally with zero latency. rst is ignored.
- Each gate's output depends only on the same-index bits of a_in/b_in. There is no carry or cross-bit interaction.
- X/Z on an input propagates per standard Verilog gate semantics. No sanitising.
- No internal state other than the output register.

Test Plan:
- WIDTH=1, REGISTER_OUT=1: rst=1 for 2 cycles with a=1, b=1 -> y_out=7'h00 throughout reset.
- rst=0; drive a=0,b=0; a=0,b=1; a=1,b=0; a=1,b=1 on consecutive edges -> y_out one cycle later is 7'h6C, 7'h56, 7'h16, 7'h23 respectively.
- Toggle b every cycle and a every two cycles over 8 cycles -> each y_out equals the expected mapping of the inputs sampled one edge earlier; field 6 changes only when a changes.
- Assert rst for 1 cycle mid-sequence while a=1, b=1 -> y_out=7'h00 on that edge; the next edge with rst=0 gives 7'h23.
- WIDTH=4: a=4'b1100, b=4'b1010 -> fields 0..6 = 1000, 1110, 0111, 0001, 0110, 1001, 0011.
- REGISTER_OUT=0: sweep all 4 input combinations with no clock -> y_out matches the mapping within the same delta cycle; rst toggling has no effect.

Source files
------------

// File: rtl/all_gate.sv
// Seven-way bitwise gate bank over two operands.
// Results packed as {~a, xnor, xor, nor, nand, or, and}.
module all_gate #(
  parameter int WIDTH        = 1,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [7*WIDTH-1:0] y_out
);

  logic [WIDTH-1:0]   g_and;
  logic [WIDTH-1:0]   g_or;
  logic [WIDTH-1:0]   g_xor;
  logic [7*WIDTH-1:0] y_nxt;

  assign g_and = a_in & b_in;
  assign g_or  = a_in | b_in;
  assign g_xor = a_in ^ b_in;

  assign y_nxt = {~a_in, ~g_xor, g_xor,
                  ~g_or, ~g_and, g_or, g_and};

  generate
    if (REGISTER_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) y_out <= '0;
        else     y_out <= y_nxt;
      end
    end else begin : g_comb
      // clk/rst are intentionally idle here
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign y_out = y_nxt;
    end
  endgenerate

endmodule

// File: tb/tb_all_gate.sv
// Directed bench for all_gate: registered W=1,
// registered W=4 and combinational W=1 variants.
module tb_all_gate;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a1  = 1'b0;
  logic       b1  = 1'b0;
  logic [3:0] a4  = '0;
  logic [3:0] b4  = '0;
  logic       ac  = 1'b0;
  logic       bc  = 1'b0;
  logic       rc  = 1'b0;

  logic [6:0]  y1;
  logic [27:0] y4;
  logic [6:0]  yc;

  int n_run  = 0;
  int n_fail = 0;

  all_gate #(.WIDTH(1), .REGISTER_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst),
    .a_in(a1), .b_in(b1), .y_out(y1)
  );

  all_gate #(.WIDTH(4), .REGISTER_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst),
    .a_in(a4), .b_in(b4), .y_out(y4)
  );

  all_gate #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_c (
    .clk(clk), .rst(rc),
    .a_in(ac), .b_in(bc), .y_out(yc)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [27:0] obs,
    input logic [27:0] exp
  );
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hand truth table for W=1, index {a,b}
  logic [6:0] tt [4];
  initial begin
    tt[0] = 7'h6C;
    tt[1] = 7'h56;
    tt[2] = 7'h16;
    tt[3] = 7'h23;
  end

  logic [3:0] f4 [7];
  initial begin
    f4[0] = 4'b1000; f4[1] = 4'b1110;
    f4[2] = 4'b0111; f4[3] = 4'b0001;
    f4[4] = 4'b0110; f4[5] = 4'b1001;
    f4[6] = 4'b0011;
  end

  initial begin
    logic [6:0] prev;
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF;
    step();
    chk("rst_c1", {21'd0, y1}, 28'd0);
    step();
    chk("rst_c2", {21'd0, y1}, 28'd0);
    chk("rst_w4", y4, 28'd0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      step();
      chk($sformatf("vec_%0d", i),
          {21'd0, y1}, {21'd0, tt[i]});
    end

    prev = y1;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'((i >> 1) & 1);
      b1 = 1'(i & 1);
      step();
      chk($sformatf("tog_%0d", i),
          {21'd0, y1}, {21'd0, tt[{a1, b1}]});
      chk($sformatf("not_%0d", i),
          {27'd0, y1[6]}, {27'd0, ~a1});
      if (i[0])
        chk($sformatf("hold6_%0d", i),
            {27'd0, y1[6]}, {27'd0, prev[6]});
      prev = y1;
    end

    a1 = 1'b1; b1 = 1'b1; rst = 1'b1;
    step();
    chk("mid_rst", {21'd0, y1}, 28'd0);
    rst = 1'b0;
    step();
    chk("post_rst", {21'd0, y1}, 28'h23);

    a4 = 4'b1100; b4 = 4'b1010;
    step();
    for (int g = 0; g < 7; g++)
      chk($sformatf("w4_f%0d", g),
          {24'd0, y4[g*4 +: 4]}, {24'd0, f4[g]});

    for (int i = 0; i < 4; i++) begin
      {ac, bc} = 2'(i);
      rc = 1'b0;
      #1;
      chk($sformatf("comb_%0d", i),
          {21'd0, yc}, {21'd0, tt[i]});
      rc = 1'b1;
      #1;
      chk($sformatf("comb_rst_%0d", i),
          {21'd0, yc}, {21'd0, tt[i]});
    end
    rc = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
